// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-select table, parity encodings, receiver FSM states.
package uart_pkg;

  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic [1:0] BAUD_SEL_2604 = 2'b00;
  localparam logic [1:0] BAUD_SEL_1302 = 2'b01;
  localparam logic [1:0] BAUD_SEL_650  = 2'b10;
  localparam logic [1:0] BAUD_SEL_22   = 2'b11;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE2 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } rx_state_e;

  // Clocks per bit for each baud select.
  function automatic logic [11:0] bitPeriod(input logic [1:0] sel);
    case (sel)
      BAUD_SEL_2604: bitPeriod = 12'd2604;
      BAUD_SEL_1302: bitPeriod = 12'd1302;
      BAUD_SEL_650:  bitPeriod = 12'd650;
      default:       bitPeriod = 12'd22;
    endcase
  endfunction

  function automatic logic [11:0] halfPeriod(input logic [1:0] sel);
    halfPeriod = bitPeriod(sel) >> 1;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART bundle: serial line and frame options in, byte and status out.
interface uart_rx_if;
  logic       rx_in;
  logic [1:0] baud_gen;
  logic       data_lengh;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    output rx_in, baud_gen, data_lengh, parity_type, stop_bits,
    input  rx_data, rx_valid, parity_err, frame_err, rx_busy
  );

  modport slave (
    input  rx_in, baud_gen, data_lengh, parity_type, stop_bits,
    output rx_data, rx_valid, parity_err, frame_err, rx_busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Serial input conditioning: STAGES synchronizer flops followed by one sampling register,
// all reset to the idle line level.
module uart_rx_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES:0] ff_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      ff_q <= {(STAGES + 1){RESET_VAL}};
    end else begin
      ff_q[0] <= d_i;
      for (int i = 1; i <= STAGES; i++) begin
        ff_q[i] <= ff_q[i-1];
      end
    end
  end

  assign q_o = ff_q[STAGES];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling FSM, 7/8 data bits, optional parity, 1/2 stop bits.
// Define UART_RX_SYNC_EN to put a 2-flop synchronizer in front of the line register.
module uart_rx #(
  parameter logic IDLE_LEVEL = uart_pkg::IDLE_LEVEL
) (
  input  logic     clock,
  input  logic     rst,
  uart_rx_if.slave bus
);
  import uart_pkg::*;

  localparam logic START_LEVEL = ~IDLE_LEVEL;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 0;
`endif

  logic       rxLine;
  logic       rxPrev_q;
  rx_state_e  state_q;
  logic [11:0] cnt_q;
  logic [2:0] idx_q;
  logic [7:0] data_q;
  logic [1:0] baud_q;
  logic       len_q;
  logic [1:0] par_q;
  logic       twoStop_q;
  logic       stopIdx_q;
  logic       perr_q;
  logic       ferr_q;
  logic [7:0] rxData_q;
  logic       rxValid_q;
  logic       parityErr_q;
  logic       frameErr_q;
  logic       rxBusy_q;

  logic [11:0] period;
  logic [11:0] half;
  logic [2:0]  lastIdx;
  logic        parEn;
  logic        parExp;

  uart_rx_sync #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(IDLE_LEVEL)
  ) u_sync (
    .clock(clock),
    .rst  (rst),
    .d_i  (bus.rx_in),
    .q_o  (rxLine)
  );

  assign period  = bitPeriod(baud_q);
  assign half    = halfPeriod(baud_q);
  assign lastIdx = len_q ? 3'd7 : 3'd6;
  assign parEn   = (par_q == PAR_ODD) || (par_q == PAR_EVEN);
  // data_q bit 7 stays cleared in 7-bit mode, so it never disturbs the reduction.
  assign parExp  = (par_q == PAR_ODD) ? ~^data_q : ^data_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      rxPrev_q    <= IDLE_LEVEL;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      baud_q      <= '0;
      len_q       <= 1'b0;
      par_q       <= '0;
      twoStop_q   <= 1'b0;
      stopIdx_q   <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      rxData_q    <= '0;
      rxValid_q   <= 1'b0;
      parityErr_q <= 1'b0;
      frameErr_q  <= 1'b0;
      rxBusy_q    <= 1'b0;
    end else begin
      rxPrev_q  <= rxLine;
      rxValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rxPrev_q == IDLE_LEVEL && rxLine == START_LEVEL) begin
            state_q   <= START;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            stopIdx_q <= 1'b0;
            rxBusy_q  <= 1'b1;
            baud_q    <= bus.baud_gen;
            len_q     <= bus.data_lengh;
            par_q     <= bus.parity_type;
            twoStop_q <= bus.stop_bits;
          end
        end
        START: begin
          if (cnt_q == half - 12'd1) begin
            cnt_q <= '0;
            if (rxLine == START_LEVEL) begin
              state_q <= DATA;
            end else begin
              state_q  <= IDLE;
              rxBusy_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        DATA: begin
          if (cnt_q == period - 12'd1) begin
            cnt_q         <= '0;
            data_q[idx_q] <= rxLine;
            if (idx_q == lastIdx) begin
              idx_q   <= '0;
              state_q <= parEn ? PARITY : STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        PARITY: begin
          if (cnt_q == period - 12'd1) begin
            cnt_q   <= '0;
            perr_q  <= (rxLine != parExp);
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        STOP: begin
          if (cnt_q == period - 12'd1) begin
            cnt_q <= '0;
            if (rxLine == START_LEVEL) begin
              ferr_q <= 1'b1;
            end
            if (twoStop_q && !stopIdx_q) begin
              stopIdx_q <= 1'b1;
            end else begin
              state_q <= DONE;
            end
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        DONE: begin
          rxData_q    <= data_q;
          parityErr_q <= perr_q;
          frameErr_q  <= ferr_q;
          rxValid_q   <= 1'b1;
          rxBusy_q    <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          rxBusy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data    = rxData_q;
  assign bus.rx_valid   = rxValid_q;
  assign bus.parity_err = parityErr_q;
  assign bus.frame_err  = frameErr_q;
  assign bus.rx_busy    = rxBusy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table of frames plus glitch, back-to-back and
// mid-frame reset sequences, with expected bytes queued at send time.
module tb_uart_rx;

  localparam int P = 22;
`ifdef UART_RX_SYNC_EN
  localparam int LAT_BASE = 16;
`else
  localparam int LAT_BASE = 14;
`endif

  logic clock = 1'b0;
  logic rst;
  always #5 clock = ~clock;

  uart_rx_if bus();

  uart_rx #(.IDLE_LEVEL(1'b1)) dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] expData;
    logic       expPerr;
    logic       expFerr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       len;
    logic [1:0] par;
    logic       two;
    logic       flipPar;
    logic       badStop;
    logic [7:0] expData;
    logic       expPerr;
    logic       expFerr;
  } vec_t;

  exp_t expQ[$];
  int   validCycles[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cycles     = 0;
  int   startCycle = 0;
  int   lastValidCycle = -1;
  vec_t vecs[6];

  always @(posedge clock) cycles <= cycles + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Every rx_valid pulse consumes one queued expectation.
  always @(negedge clock) begin
    if (bus.rx_valid === 1'b1) begin
      exp_t e;
      validCycles.push_back(cycles);
      lastValidCycle = cycles;
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected rx_valid: got data 0x%0h, expected no strobe", bus.rx_data);
      end else begin
        e = expQ.pop_front();
        checkOutput("rx_data", 32'(bus.rx_data), 32'(e.expData));
        checkOutput("parity_err", 32'(bus.parity_err), 32'(e.expPerr));
        checkOutput("frame_err", 32'(bus.frame_err), 32'(e.expFerr));
      end
    end
  end

  task automatic sendBit(input logic v);
    bus.rx_in = v;
    repeat (P) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic len, input logic [1:0] par,
                               input logic two, input logic flipPar, input logic badStop,
                               input int gap);
    int   n;
    logic pbit;
    n = len ? 8 : 7;
    bus.baud_gen    = 2'b11;
    bus.data_lengh  = len;
    bus.parity_type = par;
    bus.stop_bits   = two;
    startCycle      = cycles;
    sendBit(1'b0);
    for (int i = 0; i < n; i++) sendBit(data[i]);
    if (par == 2'b01 || par == 2'b10) begin
      pbit = 1'b0;
      for (int i = 0; i < n; i++) pbit = pbit ^ data[i];
      if (par == 2'b01) pbit = ~pbit;
      if (flipPar) pbit = ~pbit;
      sendBit(pbit);
    end
    sendBit(badStop ? 1'b0 : 1'b1);
    if (two) sendBit(1'b1);
    bus.rx_in = 1'b1;
    repeat (gap) @(posedge clock);
    #1;
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 60 && expQ.size() != 0; i++) begin
      @(posedge clock);
      #1;
    end
    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s timeout: got %0d frames pending, expected 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  function automatic int frameBits(input logic len, input logic [1:0] par, input logic two);
    frameBits = 1 + (len ? 8 : 7) + ((par == 2'b01 || par == 2'b10) ? 1 : 0) + (two ? 2 : 1);
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    bus.rx_in       = 1'b1;
    bus.baud_gen    = 2'b11;
    bus.data_lengh  = 1'b1;
    bus.parity_type = 2'b00;
    bus.stop_bits   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset outputs", 32'({bus.rx_data, bus.rx_valid, bus.parity_err, bus.frame_err, bus.rx_busy}), 32'h0);
    rst = 1'b0;
    repeat (5) @(posedge clock);
    #1;

    vecs[0] = '{8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h35, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 8'h35, 1'b0, 1'b0};
    vecs[2] = '{8'h35, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 8'h35, 1'b1, 1'b0};
    vecs[3] = '{8'h0F, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b1};
    vecs[4] = '{8'hD3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h53, 1'b0, 1'b0};
    vecs[5] = '{8'h96, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0};

    for (int v = 0; v < 6; v++) begin
      exp_t e;
      e.expData = vecs[v].expData;
      e.expPerr = vecs[v].expPerr;
      e.expFerr = vecs[v].expFerr;
      expQ.push_back(e);
      lastValidCycle = -1;
      applyStimulus(vecs[v].data, vecs[v].len, vecs[v].par, vecs[v].two,
                    vecs[v].flipPar, vecs[v].badStop, 4);
      waitDrain("vector frame");
      checkOutput("valid latency", 32'(lastValidCycle - startCycle),
                  32'(LAT_BASE + P * (frameBits(vecs[v].len, vecs[v].par, vecs[v].two) - 1)));
    end

    // Five-cycle start-level glitch must be rejected at the half-bit sample.
    bus.rx_in = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("glitch busy high", 32'(bus.rx_busy), 32'h1);
    repeat (2) @(posedge clock);
    #1;
    bus.rx_in = 1'b1;
    repeat (15) @(posedge clock);
    #1;
    checkOutput("glitch busy dropped", 32'(bus.rx_busy), 32'h0);
    repeat (10) @(posedge clock);
    #1;
    expQ.push_back('{8'h3C, 1'b0, 1'b0});
    applyStimulus(8'h3C, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4);
    waitDrain("post-glitch frame");

    // Back-to-back 8N1 frames with no idle gap.
    validCycles.delete();
    expQ.push_back('{8'h00, 1'b0, 1'b0});
    expQ.push_back('{8'hFF, 1'b0, 1'b0});
    applyStimulus(8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(8'hFF, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4);
    waitDrain("back-to-back frames");
    checkOutput("b2b pulse count", 32'(validCycles.size()), 32'd2);
    if (validCycles.size() == 2)
      checkOutput("b2b spacing", 32'(validCycles[1] - validCycles[0]), 32'(P * 10));

    // Reset in the middle of the data bits aborts the frame.
    bus.baud_gen    = 2'b11;
    bus.data_lengh  = 1'b1;
    bus.parity_type = 2'b00;
    bus.stop_bits   = 1'b0;
    sendBit(1'b0);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    checkOutput("busy mid-frame", 32'(bus.rx_busy), 32'h1);
    rst = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("mid-frame reset outputs", 32'({bus.rx_data, bus.rx_valid, bus.parity_err, bus.frame_err, bus.rx_busy}), 32'h0);
    rst       = 1'b0;
    bus.rx_in = 1'b1;
    repeat (30) @(posedge clock);
    #1;
    checkOutput("no strobe after abort", 32'(validCycles.size()), 32'd2);
    expQ.push_back('{8'h5A, 1'b0, 1'b0});
    applyStimulus(8'h5A, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4);
    waitDrain("post-reset frame");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver at the far end of the UART link: it recovers frames produced by the UART transmitter path (start bit, 7 or 8 data bits LSB first, optional parity, 1 or 2 stop bits) from a single serial line. It uses the same baud-select encoding, parity-type encoding and frame options as the transmitter. It delivers each received byte with a one-cycle valid strobe and per-frame parity and framing error flags. It sits between the serial input pin and the consuming logic, clocked by the system clock.

## Interface
Parameters:
- IDLE_LEVEL, 1, line level when idle and for stop bits; the start bit is the opposite level.

Ports:
- clock  in  1  system clock; all logic is on its rising edge
- rst  in  1  reset; synchronous, active-high
- rx_in  in  1  serial line
- baud_gen  in  2  rate select: 00→2604, 01→1302, 10→650, 11→22 clocks per bit
- data_lengh  in  1  0 = 7 data bits, 1 = 8 data bits
- parity_type  in  2  00/11 = no parity bit, 01 = odd, 10 = even
- stop_bits  in  1  0 = one stop bit, 1 = two stop bits
- rx_data  out  8  received byte; bit 7 is 0 in 7-bit mode
- rx_valid  out  1  one-cycle strobe, frame complete
- parity_err  out  1  parity mismatch for the frame in rx_data
- frame_err  out  1  a stop bit was sampled at the start level
- rx_busy  out  1  high from start-bit detection until the frame ends

## Operation
- Reset: all outputs are 0 and the FSM is in IDLE. Reset has priority in every state, so asserting it mid-frame aborts the frame with no rx_valid.
- Configuration capture: baud_gen, data_lengh, parity_type and stop_bits are latched when the start edge is detected. Later changes only affect the next frame.
- Bit period P comes from the baud_gen table; H = P/2 (1302, 651, 325, 11). The 12-bit counter cnt runs 0..P-1.
- FSM:
  - IDLE: a sampled rx transition from IDLE_LEVEL to the start level moves to START, with cnt = 0 and rx_busy = 1.
  - START: at cnt = H-1, sample the line. If the sample is the start level, go to DATA with cnt = 0. Otherwise treat it as a glitch: return to IDLE with rx_busy = 0 and no strobe.
  - DATA: at cnt = P-1, sample the line and shift it into the bit index idx (LSB first). idx counts 0..N-1, where N = 7 or 8. After bit N-1, go to PARITY if parity is enabled, otherwise go to STOP.
  - PARITY: at cnt = P-1, sample the parity bit. The expected value is ~^data for odd and ^data for even, computed over the N received bits only. A mismatch sets the internal perr.
  - STOP: at cnt = P-1, sample the stop bit. The start level sets the internal ferr. With two stop bits, stay in STOP for a second sample.
  - DONE: the cycle after the final stop sample, load rx_data, parity_err = perr and frame_err = ferr, pulse rx_valid = 1, drop rx_busy to 0, and go to IDLE.
- After DONE the line is at the idle level, so back-to-back frames are accepted with no gap.
- Error flags hold their value until the next rx_valid. With parity disabled, parity_err is always 0.
- A framing error does not suppress rx_valid; the byte is still delivered with frame_err = 1.

## Timing
- All samples are taken mid-bit: H-1 cycles after the start edge for the start bit, then every P cycles after that.
- rx_valid rises exactly 1 cycle after the last stop-bit sample and lasts 1 cycle. rx_data and the error flags are valid in that same cycle.
- Edge detection latency is 1 cycle after the sampled line changes. The synchronizer adds 2 more cycles (see Configuration).
- Frame length in bits is 1 + N + (1 if parity enabled) + stop count. The strobe falls about H cycles before the nominal end of the last stop bit.

## Configuration
- UART_RX_SYNC_EN:
  - Defined: rx_in passes through a 2-flop synchronizer reset to IDLE_LEVEL, and all timing above shifts 2 cycles later.
  - Undefined: rx_in is registered once and used directly, for on-chip loopback where rx_in is already synchronous to clock.

## Structure
- Shared package uart_pkg:
  - baud-select encodings and the P/H constant table (shared with the transmitter baud generator)
  - parity_type encodings
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP, DONE)
  - constant IDLE_LEVEL
- One natural sub-module: uart_rx_sync, the 2-flop synchronizer instantiated under UART_RX_SYNC_EN. The FSM, counter and shifter stay in uart_rx.

## Test plan
All scenarios use baud_gen = 11 (P = 22).
- 8 data bits, no parity, 1 stop, byte 0xA5 → rx_valid pulse with rx_data = 0xA5 and both error flags 0.
- 7 data bits, even parity, 2 stops, byte 0x35 with correct parity bit 0 → rx_data = 0x35 with no errors. Repeat with the parity bit flipped → parity_err = 1.
- Odd parity, byte 0x0F, stop bit forced to the start level → rx_valid with rx_data = 0x0F and frame_err = 1.
- Start-level glitch of 5 cycles on an idle line → no rx_valid, rx_busy returns to 0 at cycle H-1 after the edge, and a following valid frame 0x3C is received correctly.
- Two back-to-back frames 0x00 then 0xFF with no idle gap → two rx_valid pulses 22×10 cycles apart, data correct.
- rst asserted mid-DATA → the next cycle shows all outputs 0 and no rx_valid. A frame sent after reset is released is received correctly.
